// File: rtl/imem_loader_if.sv
// Bus bundle for the boot loader: UART input plus the instruction-memory write port
// and the core-release/status outputs.
interface imem_loader_if;
  logic        uart_rx;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;

  modport master (
    input  uart_rx,
    output imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );

  modport slave (
    output uart_rx,
    input  imem_we, imem_addr, imem_wdata, core_rst, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// UART boot loader: receives A5/LEN/payload/CSUM frames, writes words into instruction
// memory and releases the core reset once the XOR checksum matches.
module imem_loader #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.master bus
);

  localparam int             BW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0]  HALF_M1 = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0]  FULL_M1 = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]    MAX_W   = 32'(MAX_WORDS);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_IDLE   = 3'd0;
  localparam logic [2:0] LD_LEN_LO = 3'd1;
  localparam logic [2:0] LD_LEN_HI = 3'd2;
  localparam logic [2:0] LD_DATA   = 3'd3;
  localparam logic [2:0] LD_CSUM   = 3'd4;
  localparam logic [2:0] LD_DONE   = 3'd5;
  localparam logic [2:0] LD_ERR    = 3'd6;

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;

  logic [2:0]    ld_st_q, ld_st_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   widx_q, widx_d;
  logic [1:0]    bidx_q, bidx_d;
  logic [7:0]    csum_q, csum_d;
  logic [23:0]   asm_q, asm_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          core_rst_q, core_rst_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [15:0]   n_w;

  // RX: the entry count of 1 lines the start check up CLKS_PER_BIT/2 after the synced edge
  always_comb begin
    rx_st_d     = rx_st_q;
    baud_d      = baud_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_st_q)
      RX_IDLE: begin
        baud_d = '0;
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d = RX_START;
          baud_d  = BW'(1);
        end
      end
      RX_START: begin
        if (baud_q == HALF_M1) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (baud_q == FULL_M1) begin
          baud_d  = '0;
          shift_d = {rx_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (baud_q == FULL_M1) begin
          baud_d      = '0;
          rx_st_d     = RX_IDLE;
          byte_vld_d  = rx_s2_q;
          frame_err_d = !rx_s2_q;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  assign n_w = {shift_q, len_q[7:0]};

  // Load FSM: the address/word index advance is keyed off the registered write strobe
  always_comb begin
    ld_st_d    = ld_st_q;
    len_d      = len_q;
    widx_d     = widx_q;
    bidx_d     = bidx_q;
    csum_d     = csum_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    if (we_q) begin
      addr_d = addr_q + 32'd4;
      widx_d = widx_q + 16'd1;
    end
    case (ld_st_q)
      LD_IDLE: begin
        if (byte_vld_q && shift_q == 8'hA5) begin
          err_d   = 1'b0;
          csum_d  = 8'h00;
          bidx_d  = 2'd0;
          widx_d  = 16'd0;
          addr_d  = BASE_ADDR;
          ld_st_d = LD_LEN_LO;
        end
      end
      LD_LEN_LO: begin
        if (frame_err_q) ld_st_d = LD_ERR;
        else if (byte_vld_q) begin
          len_d[7:0] = shift_q;
          ld_st_d    = LD_LEN_HI;
        end
      end
      LD_LEN_HI: begin
        if (frame_err_q) ld_st_d = LD_ERR;
        else if (byte_vld_q) begin
          len_d   = n_w;
          ld_st_d = (n_w == 16'd0 || {16'd0, n_w} > MAX_W) ? LD_ERR : LD_DATA;
        end
      end
      LD_DATA: begin
        if (frame_err_q) ld_st_d = LD_ERR;
        else if (byte_vld_q) begin
          csum_d = csum_q ^ shift_q;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0:    asm_d[7:0]   = shift_q;
            2'd1:    asm_d[15:8]  = shift_q;
            2'd2:    asm_d[23:16] = shift_q;
            default: begin
              wdata_d = {shift_q, asm_q};
              we_d    = 1'b1;
              if (widx_q == len_q - 16'd1) ld_st_d = LD_CSUM;
            end
          endcase
        end
      end
      LD_CSUM: begin
        if (frame_err_q) ld_st_d = LD_ERR;
        else if (byte_vld_q) begin
          if (shift_q == csum_q) begin
            ld_st_d    = LD_DONE;
            core_rst_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            ld_st_d = LD_ERR;
          end
        end
      end
      LD_DONE: ld_st_d = LD_DONE;
      default: ld_st_d = LD_IDLE;
    endcase
    if (ld_st_d == LD_ERR && ld_st_q != LD_ERR) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_st_q     <= RX_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ld_st_q     <= LD_IDLE;
      len_q       <= 16'd0;
      widx_q      <= 16'd0;
      bidx_q      <= 2'd0;
      csum_q      <= 8'h00;
      we_q        <= 1'b0;
      addr_q      <= BASE_ADDR;
      wdata_q     <= 32'd0;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_s1_q     <= bus.uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_st_q     <= rx_st_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      ld_st_q     <= ld_st_d;
      len_q       <= len_d;
      widx_q      <= widx_d;
      bidx_q      <= bidx_d;
      csum_q      <= csum_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    asm_q   <= asm_d;
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.core_rst   = core_rst_q;
  assign bus.load_done  = done_q;
  assign bus.load_err   = err_q;

endmodule
